// File: rtl/result_demux_if.sv
// Handshake bundle for result_demux: producer-side result port plus the
// per-destination steering outputs. master = producer/consumers, slave = the demux.
interface result_demux_if #(
    parameter int W     = 8,
    parameter int NDEST = 2,
    parameter int SELW  = 1
);
    // A word moves on a channel at a rising edge where valid && ready are both 1;
    // valid never waits on ready, and ready here depends only on registered state.
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [SELW-1:0]  in_sel;
    logic [NDEST-1:0] out_valid;
    logic [NDEST-1:0] out_ready;
    logic [W-1:0]     out_data;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/result_demux.sv
// Write-back steering stage: a 2-entry in-order buffer of {data, sel} whose head
// is presented to exactly one destination; out-of-range selects are dropped and flagged.
module result_demux #(
    parameter int W     = 8,
    parameter int NDEST = 2,
    parameter int SELW  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    result_demux_if.slave    bus,
    input  logic             err_clr,
    output logic             err,
    output logic [1:0]       dbg_count
);

    logic [W-1:0]    buf_data [2];
    logic [SELW-1:0] buf_sel  [2];
    logic            head;
    logic            tail;
    logic [1:0]      count;

    logic            head_valid;
    logic [SELW-1:0] head_sel;
    logic            sel_ok;
    logic            accept;
    logic            push;
    logic            pop;

    assign head_valid   = (count != 2'd0);
    assign head_sel     = buf_sel[head];
    assign bus.in_ready = (count != 2'd2);
    assign dbg_count    = count;

    assign sel_ok = ({1'b0, bus.in_sel} < (SELW+1)'(NDEST));
    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && sel_ok;

    // Only the head entry is ever visible, so a stalled head blocks every later word.
    always_comb begin
        bus.out_valid = '0;
        for (int d = 0; d < NDEST; d++) begin
            bus.out_valid[d] = head_valid && (head_sel == SELW'(d));
        end
    end

    assign bus.out_data = head_valid ? buf_data[head] : '0;
    assign pop          = |(bus.out_valid & bus.out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head        <= 1'b0;
            tail        <= 1'b0;
            count       <= 2'd0;
            err         <= 1'b0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_sel[0]  <= '0;
            buf_sel[1]  <= '0;
        end else begin
            if (push) begin
                buf_data[tail] <= bus.in_data;
                buf_sel[tail]  <= bus.in_sel;
                tail           <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
            // A dropped word in the same cycle as a clear leaves the flag set.
            if (accept && !sel_ok) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_result_demux.sv
// Bench for result_demux: queue-based reference model checked every cycle on the
// default 2-destination instance, plus directed checks on a 3-destination instance.
module tb_result_demux;

  logic clk;
  logic rst_n;
  logic rst3_n;
  logic err_clr;
  logic err;
  logic [1:0] dbg_count;
  logic err_clr3;
  logic err3;
  logic [1:0] count3;

  int n_checks;
  int n_errors;
  logic chk_en;
  int words_out;

  result_demux_if #(.W(8), .NDEST(2), .SELW(1)) bus ();
  result_demux_if #(.W(8), .NDEST(3), .SELW(2)) bus3 ();

  result_demux #(.W(8), .NDEST(2), .SELW(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .err_clr(err_clr), .err(err), .dbg_count(dbg_count)
  );

  result_demux #(.W(8), .NDEST(3), .SELW(2)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .bus(bus3), .err_clr(err_clr3), .err(err3), .dbg_count(count3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: words in program order as {sel, data}
  logic [8:0] exp_q[$];
  logic m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_err <= 1'b0;
    end else begin
      int n;
      logic do_acc;
      logic do_pop;
      n = exp_q.size();
      do_acc = bus.in_valid && (n < 2);
      do_pop = (n > 0) && bus.out_ready[exp_q[0][8]];
      if (do_pop) begin
        void'(exp_q.pop_front());
        words_out <= words_out + 1;
      end
      if (do_acc) exp_q.push_back({bus.in_sel, bus.in_data});
      if (err_clr) m_err <= 1'b0;
    end
  end

  // per-cycle compare, sampled away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] ev;
      logic [7:0] ed;
      int n;
      n = exp_q.size();
      ev = 2'b00;
      ed = 8'h00;
      if (n > 0) begin
        ev = 2'b01 << exp_q[0][8];
        ed = exp_q[0][7:0];
      end
      chk("cycle", {19'd0, bus.in_ready, bus.out_valid, bus.out_data, err, dbg_count},
          {19'd0, (n < 2), ev, ed, m_err, 2'(n)});
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic [1:0] rdy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_sel    = s;
    bus.out_ready = rdy;
  endtask

  task automatic drive3(input logic v, input logic [7:0] d, input logic [1:0] s, input logic [2:0] rdy);
    bus3.in_valid  = v;
    bus3.in_data   = d;
    bus3.in_sel    = s;
    bus3.out_ready = rdy;
  endtask

  task automatic expect_out(input string name, input logic rdy, input logic [1:0] v, input logic [7:0] d);
    chk(name, {22'd0, bus.in_ready, bus.out_valid, bus.out_data}, {22'd0, rdy, v, d});
  endtask

  initial begin
    int target;
    int cyc;
    n_checks = 0;
    n_errors = 0;
    chk_en = 1'b0;
    words_out = 0;
    m_err = 1'b0;
    rst_n = 1'b0;
    rst3_n = 1'b0;
    err_clr = 1'b0;
    err_clr3 = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 2'b00);
    drive3(1'b0, 8'h00, 2'd0, 3'b000);

    @(negedge clk);
    expect_out("reset_out", 1'b1, 2'b00, 8'h00);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_count", {30'd0, dbg_count}, 32'd0);
    rst_n = 1'b1;
    rst3_n = 1'b1;
    chk_en = 1'b1;

    // streaming
    drive(1'b1, 8'h11, 1'b0, 2'b11);
    @(negedge clk); expect_out("stream_1", 1'b1, 2'b01, 8'h11);
    drive(1'b1, 8'h22, 1'b1, 2'b11);
    @(negedge clk); expect_out("stream_2", 1'b1, 2'b10, 8'h22);
    drive(1'b1, 8'h33, 1'b0, 2'b11);
    @(negedge clk); expect_out("stream_3", 1'b1, 2'b01, 8'h33);
    drive(1'b0, 8'h00, 1'b0, 2'b11);
    @(negedge clk); expect_out("stream_empty", 1'b1, 2'b00, 8'h00);

    // backpressure and head-of-line blocking
    drive(1'b1, 8'hA0, 1'b0, 2'b10);
    @(negedge clk); expect_out("hol_1", 1'b1, 2'b01, 8'hA0);
    drive(1'b1, 8'hB1, 1'b1, 2'b10);
    @(negedge clk); expect_out("hol_full", 1'b0, 2'b01, 8'hA0);
    chk("hol_count", {30'd0, dbg_count}, 32'd2);
    drive(1'b0, 8'h00, 1'b0, 2'b10);
    @(negedge clk); expect_out("hol_hold", 1'b0, 2'b01, 8'hA0);
    drive(1'b0, 8'h00, 1'b0, 2'b11);
    @(negedge clk); expect_out("hol_release", 1'b1, 2'b10, 8'hB1);
    @(negedge clk); expect_out("hol_empty", 1'b1, 2'b00, 8'h00);

    // push and pop together at one entry
    drive(1'b1, 8'h40, 1'b1, 2'b00);
    @(negedge clk); expect_out("pp_one", 1'b1, 2'b10, 8'h40);
    drive(1'b1, 8'h5C, 1'b0, 2'b10);
    @(negedge clk); expect_out("pp_swap", 1'b1, 2'b01, 8'h5C);
    chk("pp_count", {30'd0, dbg_count}, 32'd1);
    drive(1'b0, 8'h00, 1'b0, 2'b01);
    @(negedge clk); expect_out("pp_empty", 1'b1, 2'b00, 8'h00);

    // reset with two entries buffered
    drive(1'b1, 8'h61, 1'b0, 2'b00);
    @(negedge clk);
    drive(1'b1, 8'h72, 1'b1, 2'b00);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 2'b00);
    chk("mid_count", {30'd0, dbg_count}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    expect_out("mid_reset", 1'b1, 2'b00, 8'h00);
    chk("mid_reset_state", {29'd0, err, dbg_count}, 32'd0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk); expect_out("post_reset", 1'b1, 2'b00, 8'h00);

    // invalid select on the 3-destination instance
    drive3(1'b1, 8'h7E, 2'd3, 3'b000);
    chk("inv_ready", {31'd0, bus3.in_ready}, 32'd1);
    @(negedge clk);
    chk("inv_err", {31'd0, err3}, 32'd1);
    chk("inv_drop", {27'd0, bus3.out_valid, count3}, 32'd0);
    drive3(1'b0, 8'h00, 2'd0, 3'b000);
    @(negedge clk);
    chk("inv_sticky", {31'd0, err3}, 32'd1);
    err_clr3 = 1'b1;
    @(negedge clk);
    chk("inv_clear", {31'd0, err3}, 32'd0);
    drive3(1'b1, 8'h7F, 2'd3, 3'b000);
    @(negedge clk);
    chk("inv_set_wins", {31'd0, err3}, 32'd1);
    err_clr3 = 1'b0;
    drive3(1'b1, 8'h9D, 2'd2, 3'b000);
    @(negedge clk);
    chk("d3_valid", {29'd0, bus3.out_valid}, 32'd4);
    chk("d3_data", {24'd0, bus3.out_data}, 32'h9D);
    drive3(1'b0, 8'h00, 2'd0, 3'b100);
    @(negedge clk);
    chk("d3_empty", {27'd0, bus3.out_valid, count3}, 32'd0);
    #2 rst3_n = 1'b0;
    #1;
    chk("d3_reset_err", {31'd0, err3}, 32'd0);
    @(negedge clk);
    rst3_n = 1'b1;

    // random traffic
    target = words_out + 10000;
    cyc = 0;
    while (words_out < target && cyc < 90000) begin
      @(negedge clk);
      cyc++;
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      err_clr = 1'($urandom_range(0, 1));
    end
    chk("random_budget", {31'd0, (words_out >= target)}, 32'd1);
    drive(1'b0, 8'h00, 1'b0, 2'b11);
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    expect_out("drain", 1'b1, 2'b00, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
